// File: rtl/demod_tune_ctrl_pkg.sv
// Shared types and helpers for the carrier acquisition / AFC controller.
package demod_tune_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StMeasure,
    StEval,
    StDecide,
    StTrack
  } state_e;

  // Width of a counter that must reach n-1.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demod_win_avg.sv
// Strobe-gated window averager: sums 2^Log2 samples, pulses done_o on the last one and
// presents the floor mean (including that last sample) in the same cycle.
module demod_win_avg #(
  parameter int unsigned Width  = 12,
  parameter int unsigned Log2   = 8,
  parameter bit          Signed = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [Width-1:0] data_i,
  output logic             done_o,
  output logic [Width-1:0] mean_o
);

  localparam int unsigned AccW = Width + Log2;

  logic [AccW-1:0] acc_q, acc_d, data_ext, sum;
  logic [Log2-1:0] cnt_q, cnt_d;

  always_comb begin
    if (Signed) data_ext = {{Log2{data_i[Width-1]}}, data_i};
    else        data_ext = {{Log2{1'b0}}, data_i};
    sum    = acc_q + data_ext;
    done_o = en_i && !clr_i && (cnt_q == '1);
    if (Signed) mean_o = Width'($signed(sum) >>> Log2);
    else        mean_o = Width'(sum >> Log2);
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (en_i) begin
      // Counter wraps to zero on the last sample, so the next window starts clean.
      cnt_d = cnt_q + 1'b1;
      acc_d = done_o ? '0 : sum;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demod_tune_ctrl.sv
// Carrier acquisition and AFC controller: sweeps the NCO word, locks on the strongest
// mean AM step, then trims the word from the mean FM discriminator output.
module demod_tune_ctrl
  import demod_tune_ctrl_pkg::*;
#(
  parameter int unsigned PHASE_WIDTH  = 32,
  parameter int unsigned OUTPUT_WIDTH = 12,
  parameter int unsigned STEP_WIDTH   = 8,
  parameter int unsigned SETTLE_CYC   = 64,
  parameter int unsigned MEAS_LOG2    = 8,
  parameter int unsigned AFC_SHIFT    = 4
) (
  input  logic                    clk_in,
  input  logic                    RST,
  input  logic                    start,
  input  logic                    abort,
  input  logic [PHASE_WIDTH-1:0]  f_start,
  input  logic [PHASE_WIDTH-1:0]  f_step,
  input  logic [STEP_WIDTH-1:0]   n_steps,
  input  logic [OUTPUT_WIDTH-1:0] lock_thresh,
  input  logic                    sample_valid,
  input  logic [OUTPUT_WIDTH-1:0] am_in,
  input  logic [OUTPUT_WIDTH-1:0] fm_in,
  output logic [PHASE_WIDTH-1:0]  Fre_word,
  output logic                    busy,
  output logic                    locked,
  output logic                    fail,
  output logic [OUTPUT_WIDTH-1:0] peak_mag
);

  localparam int unsigned SettleW = cnt_w(SETTLE_CYC);

  state_e                  state_q, state_d;
  logic [PHASE_WIDTH-1:0]  word_q, word_d, peak_word_q, peak_word_d;
  logic [PHASE_WIDTH-1:0]  fs_q, fs_d, step_q, step_d, afc_delta;
  logic [STEP_WIDTH-1:0]   n_q, n_d, idx_q, idx_d, last_idx;
  logic [OUTPUT_WIDTH-1:0] thresh_q, thresh_d, peak_q, peak_d, am_mean_q, am_mean_d;
  logic [OUTPUT_WIDTH-1:0] am_mean, fm_mean;
  logic [SettleW-1:0]      settle_q, settle_d;
  logic                    locked_q, locked_d, fail_q, fail_d;
  logic                    win_en, win_clr, am_done, fm_done, win_done;

  assign win_en   = sample_valid && (state_q == StMeasure || state_q == StTrack);
  assign win_clr  = !(state_q == StMeasure || state_q == StTrack);
  assign win_done = am_done && fm_done;
  assign last_idx = (n_q == '0) ? '0 : n_q - 1'b1;
  assign afc_delta = PHASE_WIDTH'($signed(fm_mean)) << AFC_SHIFT;

  demod_win_avg #(.Width(OUTPUT_WIDTH), .Log2(MEAS_LOG2), .Signed(1'b0)) u_am_avg (
    .clk_i  (clk_in),
    .rst_i  (RST),
    .clr_i  (win_clr),
    .en_i   (win_en),
    .data_i (am_in),
    .done_o (am_done),
    .mean_o (am_mean)
  );

  demod_win_avg #(.Width(OUTPUT_WIDTH), .Log2(MEAS_LOG2), .Signed(1'b1)) u_fm_avg (
    .clk_i  (clk_in),
    .rst_i  (RST),
    .clr_i  (win_clr),
    .en_i   (win_en),
    .data_i (fm_in),
    .done_o (fm_done),
    .mean_o (fm_mean)
  );

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    peak_word_d = peak_word_q;
    fs_d        = fs_q;
    step_d      = step_q;
    n_d         = n_q;
    thresh_d    = thresh_q;
    idx_d       = idx_q;
    peak_d      = peak_q;
    am_mean_d   = am_mean_q;
    settle_d    = settle_q;
    locked_d    = locked_q;
    fail_d      = 1'b0;
    if (abort) begin
      state_d  = StIdle;
      locked_d = 1'b0;
      settle_d = '0;
    end else begin
      unique case (state_q)
        StIdle: if (start) begin
          fs_d        = f_start;
          step_d      = f_step;
          n_d         = n_steps;
          thresh_d    = lock_thresh;
          word_d      = f_start;
          peak_word_d = f_start;
          idx_d       = '0;
          peak_d      = '0;
          settle_d    = '0;
          state_d     = StSettle;
        end
        StSettle: if (sample_valid) begin
          if (settle_q == SettleW'(SETTLE_CYC - 1)) begin
            settle_d = '0;
            state_d  = StMeasure;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        StMeasure: if (win_done) begin
          am_mean_d = am_mean;
          state_d   = StEval;
        end
        StEval: begin
          // Strict compare keeps the earliest step on ties.
          if (am_mean_q > peak_q) begin
            peak_d      = am_mean_q;
            peak_word_d = word_q;
          end
          if (idx_q == last_idx) begin
            state_d = StDecide;
          end else begin
            word_d  = word_q + step_q;
            idx_d   = idx_q + 1'b1;
            state_d = StSettle;
          end
        end
        StDecide: begin
          if (peak_q >= thresh_q) begin
            word_d  = peak_word_q;
            state_d = StTrack;
          end else begin
            fail_d  = 1'b1;
            state_d = StIdle;
          end
        end
        StTrack: if (win_done) begin
          if (am_mean < (thresh_q >> 1)) begin
            // Carrier lost: rerun the sweep from the latched configuration.
            locked_d    = 1'b0;
            word_d      = fs_q;
            peak_word_d = fs_q;
            idx_d       = '0;
            peak_d      = '0;
            settle_d    = '0;
            state_d     = StSettle;
          end else begin
            locked_d = 1'b1;
            word_d   = word_q + afc_delta;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      word_q      <= '0;
      peak_word_q <= '0;
      fs_q        <= '0;
      step_q      <= '0;
      n_q         <= '0;
      thresh_q    <= '0;
      idx_q       <= '0;
      peak_q      <= '0;
      am_mean_q   <= '0;
      settle_q    <= '0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      peak_word_q <= peak_word_d;
      fs_q        <= fs_d;
      step_q      <= step_d;
      n_q         <= n_d;
      thresh_q    <= thresh_d;
      idx_q       <= idx_d;
      peak_q      <= peak_d;
      am_mean_q   <= am_mean_d;
      settle_q    <= settle_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
    end
  end

  assign Fre_word = word_q;
  assign busy     = (state_q != StIdle);
  assign locked   = locked_q;
  assign fail     = fail_q;
  assign peak_mag = peak_q;

endmodule

// File: tb/tb_demod_tune_ctrl.sv
// Bench for demod_tune_ctrl: a frequency-dependent signal environment, a step-level
// reference model predicting every change of {Fre_word, locked, fail}, and a monitor.
module tb_demod_tune_ctrl;

  localparam int unsigned PW = 32;
  localparam int unsigned OW = 12;
  localparam int unsigned SW = 8;

  logic          clk = 1'b0;
  logic          rst, start, abort, sample_valid;
  logic [PW-1:0] f_start, f_step, fre_word;
  logic [SW-1:0] n_steps;
  logic [OW-1:0] lock_thresh, am_in, fm_in, peak_mag;
  logic          busy, locked, fail;

  always #5 clk = ~clk;

  demod_tune_ctrl dut (
    .clk_in       (clk),
    .RST          (rst),
    .start        (start),
    .abort        (abort),
    .f_start      (f_start),
    .f_step       (f_step),
    .n_steps      (n_steps),
    .lock_thresh  (lock_thresh),
    .sample_valid (sample_valid),
    .am_in        (am_in),
    .fm_in        (fm_in),
    .Fre_word     (fre_word),
    .busy         (busy),
    .locked       (locked),
    .fail         (fail),
    .peak_mag     (peak_mag)
  );

  typedef struct packed {
    logic [31:0] word;
    logic        lck;
    logic        fl;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Signal environment: mean AM seen at each NCO word, background elsewhere.
  int          am_tbl[bit [31:0]];
  int          env_bg = 0;
  int          env_fm = 0;
  int          strobe_cnt = 0;
  bit          mon_on = 1'b0;
  obs_t        prev_obs = '0;

  // Model state
  logic [31:0] m_word = '0;
  logic        m_lck = 1'b0;
  logic        m_fl = 1'b0;
  int          m_peak = 0;
  logic [31:0] c_fs, c_step;
  int          c_n, c_th;

  function automatic int am_of(input logic [31:0] w);
    return am_tbl.exists(w) ? am_tbl[w] : env_bg;
  endfunction

  task automatic check(input string name, input longint got, input longint req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic push_obs(input logic [31:0] w, input logic l, input logic f);
    obs_t o;
    o = {w, l, f};
    if (o != {m_word, m_lck, m_fl}) exp_q.push_back(o);
    m_word = w;
    m_lck  = l;
    m_fl   = f;
  endtask

  task automatic model_sweep(output bit ok, output logic [31:0] pw);
    logic [31:0] w;
    int best;
    w = c_fs;
    best = 0;
    pw = c_fs;
    m_peak = 0;
    push_obs(w, 1'b0, 1'b0);
    for (int k = 0; k < c_n; k++) begin
      if (k > 0) begin
        w = w + c_step;
        push_obs(w, 1'b0, 1'b0);
      end
      if (am_of(w) > best) begin
        best = am_of(w);
        pw = w;
      end
    end
    m_peak = best;
    ok = (best >= c_th);
  endtask

  // Predicts sweeps and up to three tracking windows, at most two sweep passes.
  task automatic model_run(output bit ends_fail);
    bit ok, lost;
    logic [31:0] pw, w;
    int sweeps, wins;
    sweeps = 0;
    wins = 0;
    ends_fail = 1'b0;
    while (1) begin
      model_sweep(ok, pw);
      sweeps++;
      if (!ok) begin
        push_obs(m_word, 1'b0, 1'b1);
        push_obs(m_word, 1'b0, 1'b0);
        ends_fail = 1'b1;
        return;
      end
      w = pw;
      push_obs(w, 1'b0, 1'b0);
      lost = 1'b0;
      while (!lost && wins < 3) begin
        wins++;
        if (am_of(w) < c_th / 2) begin
          lost = 1'b1;
          m_peak = 0;
          push_obs(c_fs, 1'b0, 1'b0);
        end else begin
          w = w + 32'(env_fm * 16);
          push_obs(w, 1'b1, 1'b0);
        end
      end
      if (!lost || sweeps >= 2) return;
    end
  endtask

  // Environment driver
  initial begin
    sample_valid = 1'b0;
    am_in = '0;
    fm_in = '0;
    forever begin
      @(posedge clk);
      #1;
      sample_valid = ($urandom_range(0, 3) != 0);
      am_in = OW'(am_of(fre_word));
      fm_in = OW'(env_fm);
      if (sample_valid) strobe_cnt++;
    end
  end

  // Monitor: every change of the observable tuple must match the next prediction.
  initial begin
    obs_t cur, e;
    bit fail_prev;
    fail_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_on) begin
        cur = {fre_word, locked, fail};
        if (cur != prev_obs) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got word=%0d locked=%0b fail=%0b, required no change",
                     cur.word, cur.lck, cur.fl);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              errors++;
              $display("FAIL event: got word=%0d locked=%0b fail=%0b, required word=%0d locked=%0b fail=%0b",
                       cur.word, cur.lck, cur.fl, e.word, e.lck, e.fl);
            end
          end
          prev_obs = cur;
        end
        if (fail) begin
          checks++;
          if (fail_prev) begin
            errors++;
            $display("FAIL fail_pulse_width: got fail high 2+ cycles, required 1 cycle");
          end
        end
        fail_prev = fail;
      end
    end
  end

  task automatic scramble_cfg();
    f_start = $urandom;
    f_step = $urandom;
    n_steps = SW'($urandom);
    lock_thresh = OW'($urandom);
  endtask

  // Caller sets am_tbl and enters at posedge+#1.
  task automatic run_scn(input logic [31:0] fs, input logic [31:0] st, input int n,
                         input int th, input int fm, input int bg, input string tag);
    bit ends_fail;
    int t;
    c_fs = fs;
    c_step = st;
    c_n = (n == 0) ? 1 : n;
    c_th = th;
    env_fm = fm;
    env_bg = bg;
    model_run(ends_fail);
    f_start = fs;
    f_step = st;
    n_steps = SW'(n);
    lock_thresh = OW'(th);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    scramble_cfg();
    repeat (20) @(posedge clk);
    #1;
    start = 1'b1;  // busy: must be ignored
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (exp_q.size() != 0 && t < 40000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check({tag, "_events_seen"}, exp_q.size(), 0);
    exp_q.delete();
    check({tag, "_peak_mag"}, peak_mag, m_peak);
    check({tag, "_locked"}, locked, m_lck);
    if (ends_fail) begin
      check({tag, "_busy_after_fail"}, busy, 0);
    end else begin
      check({tag, "_busy_active"}, busy, 1);
      push_obs(m_word, 1'b0, 1'b0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check({tag, "_busy_after_abort"}, busy, 0);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int t, s0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    f_start = '0;
    f_step = '0;
    n_steps = '0;
    lock_thresh = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_word", fre_word, 0);
    check("reset_busy", busy, 0);
    check("reset_locked", locked, 0);
    check("reset_fail", fail, 0);
    check("reset_peak", peak_mag, 0);
    rst = 1'b0;
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    // start and abort together: abort wins
    f_start = 777;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_busy", busy, 0);
    check("start_abort_word", fre_word, 0);

    // Sweep with a tie at the peak
    am_tbl.delete();
    am_tbl[1000] = 50; am_tbl[1100] = 80; am_tbl[1200] = 80; am_tbl[1300] = 30;
    run_scn(1000, 100, 4, 60, 0, 0, "sweep");

    // No signal
    am_tbl.delete();
    am_tbl[2000] = 10; am_tbl[2100] = 10; am_tbl[2200] = 10; am_tbl[2300] = 10;
    run_scn(2000, 100, 4, 60, 0, 10, "nosig");

    // AFC pulls the word down by 32 per window while lock holds
    am_tbl.delete();
    am_tbl[1000] = 50; am_tbl[1100] = 80;
    run_scn(1000, 100, 2, 60, -2, 70, "afc");

    // Frequency word wrap
    am_tbl.delete();
    run_scn(32'hFFFF_FFCE, 100, 2, 60, 0, 0, "wrap");

    // Abort mid-MEASURE of the second step, then restart next cycle
    am_tbl.delete();
    am_tbl[5000] = 100; am_tbl[5300] = 100; am_tbl[5600] = 100;
    env_bg = 0;
    env_fm = 0;
    push_obs(5000, 1'b0, 1'b0);
    push_obs(5300, 1'b0, 1'b0);
    f_start = 5000;
    f_step = 300;
    n_steps = 3;
    lock_thresh = 60;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t = 0;
    while (fre_word != 5300 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    s0 = strobe_cnt;
    t = 0;
    while (strobe_cnt < s0 + 114 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_word_hold", fre_word, m_word);
    check("abort_events_seen", exp_q.size(), 0);
    exp_q.delete();
    run_scn(5000, 300, 3, 60, 0, 0, "restart");

    // Loss of lock after AFC walks off the carrier
    am_tbl.delete();
    am_tbl[1000] = 50; am_tbl[1100] = 80;
    run_scn(1000, 100, 2, 60, -2, 10, "loss");

    // Randomized sweeps
    for (int r = 0; r < 6; r++) begin
      logic [31:0] fs, st;
      int n;
      fs = $urandom;
      st = $urandom | 32'd1;
      n = int'($urandom_range(0, 4));
      am_tbl.delete();
      for (int k = 0; k < ((n == 0) ? 1 : n); k++) am_tbl[fs + 32'(k) * st] = int'($urandom_range(0, 5)) * 30;
      run_scn(fs, st, n, int'($urandom_range(0, 5)) * 30, int'($urandom_range(0, 15)) - 8,
              int'($urandom_range(0, 4)) * 30, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
